// File: rtl/emin_pkg.sv
// emin_pkg: shared constants and scheduler state type for the emin datapath.
package emin_pkg;
  localparam int EMIN_I_MAX = 160;
  localparam int EMIN_BIT_WIDTH = 32;
  localparam int EMIN_TIMEOUT = 64;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_FIN} emin_sched_state_t;
endpackage

// File: rtl/emin_scheduler_if.sv
// emin_scheduler_if: controller, emin and result-buffer signals seen by the scheduler.
interface emin_scheduler_if #(
  parameter int BIT_WIDTH = emin_pkg::EMIN_BIT_WIDTH,
  parameter int I = emin_pkg::EMIN_I_MAX,
  parameter int ADDR_WIDTH = $clog2(I * (I + 1) / 2)
);
  logic start_in;
  logic [$clog2(I):0] n_in;
  logic busy_out;
  logic done_out;
  logic error_out;
  logic [$clog2(I)-1:0] emin_i_out;
  logic emin_valid_out;
  logic [$clog2(I)-1:0] emin_j_in;
  logic [BIT_WIDTH-1:0] emin_data_in;
  logic emin_valid_in;
  logic wr_en_out;
  logic [ADDR_WIDTH-1:0] wr_addr_out;
  logic [BIT_WIDTH-1:0] wr_data_out;
  modport master (
    input start_in, n_in, emin_j_in, emin_data_in, emin_valid_in,
    output busy_out, done_out, error_out, emin_i_out, emin_valid_out,
    output wr_en_out, wr_addr_out, wr_data_out
  );
  modport slave (
    output start_in, n_in, emin_j_in, emin_data_in, emin_valid_in,
    input busy_out, done_out, error_out, emin_i_out, emin_valid_out,
    input wr_en_out, wr_addr_out, wr_data_out
  );
endinterface

// File: rtl/emin_scheduler.sv
// emin_scheduler: sweeps emin over i = 0..n-1 and stores Emin(j,i) at i(i+1)/2 + j.
module emin_scheduler
  import emin_pkg::*;
#(
  parameter int BIT_WIDTH = EMIN_BIT_WIDTH,
  parameter int I = EMIN_I_MAX,
  parameter int ADDR_WIDTH = $clog2(I * (I + 1) / 2),
  parameter int TIMEOUT = EMIN_TIMEOUT
) (
  input logic clk_in,
  input logic rst_n_in,
  emin_scheduler_if.master bus
);
  localparam int IW = $clog2(I);
  localparam int WW = $clog2(TIMEOUT + 1);
  emin_sched_state_t state_q;
  logic [IW:0] n_q;
  logic [IW-1:0] cur_i_q, exp_j_q, emin_i_q;
  logic [ADDR_WIDTH-1:0] base_q, wr_addr_q;
  logic [WW-1:0] wd_q;
  logic [BIT_WIDTH-1:0] wr_data_q;
  logic busy_q, done_q, error_q, valid_q, wr_en_q;
  logic [IW:0] next_i;
  assign next_i = {1'b0, cur_i_q} + (IW + 1)'(1);
  assign bus.busy_out = busy_q;
  assign bus.done_out = done_q;
  assign bus.error_out = error_q;
  assign bus.emin_i_out = emin_i_q;
  assign bus.emin_valid_out = valid_q;
  assign bus.wr_en_out = wr_en_q;
  assign bus.wr_addr_out = wr_addr_q;
  assign bus.wr_data_out = wr_data_q;
  // Back-to-back items raise the issue pulse straight from WAIT so it lands the cycle after the last j;
  // ISSUE then only completes a pulse that is not already out.
  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      n_q <= '0;
      cur_i_q <= '0;
      exp_j_q <= '0;
      emin_i_q <= '0;
      base_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wd_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      error_q <= 1'b0;
      valid_q <= 1'b0;
      wr_en_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      valid_q <= 1'b0;
      wr_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (bus.start_in) begin
          n_q <= (bus.n_in > (IW + 1)'(I)) ? (IW + 1)'(I) : bus.n_in;
          error_q <= 1'b0;
          busy_q <= 1'b1;
          cur_i_q <= '0;
          exp_j_q <= '0;
          base_q <= '0;
          state_q <= (bus.n_in == '0) ? ST_FIN : ST_ISSUE;
        end
        ST_ISSUE: begin
          valid_q <= ~valid_q;
          emin_i_q <= cur_i_q;
          wd_q <= WW'(valid_q);
          state_q <= ST_WAIT;
        end
        ST_WAIT: if (bus.emin_valid_in) begin
          if (bus.emin_j_in != exp_j_q) begin
            error_q <= 1'b1;
            state_q <= ST_FIN;
          end else begin
            wr_en_q <= 1'b1;
            wr_addr_q <= base_q + ADDR_WIDTH'(exp_j_q);
            wr_data_q <= bus.emin_data_in;
            wd_q <= '0;
            if (exp_j_q == cur_i_q) begin
              base_q <= base_q + ADDR_WIDTH'(next_i);
              cur_i_q <= next_i[IW-1:0];
              exp_j_q <= '0;
              valid_q <= next_i != n_q;
              if (next_i != n_q) emin_i_q <= next_i[IW-1:0];
              state_q <= (next_i == n_q) ? ST_FIN : ST_ISSUE;
            end else exp_j_q <= exp_j_q + IW'(1);
          end
        end else if (wd_q == WW'(TIMEOUT)) begin
          error_q <= 1'b1;
          state_q <= ST_FIN;
        end else wd_q <= wd_q + WW'(1);
        ST_FIN: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
endmodule

// File: tb/tb_emin_scheduler.sv
// tb_emin_scheduler: randomized emin responder checked against a triangular-address reference model.
module tb_emin_scheduler;
  import emin_pkg::*;
  localparam int I = EMIN_I_MAX;
  localparam int T = EMIN_TIMEOUT;
  localparam int IW = $clog2(I);
  localparam int NW = $clog2(I) + 1;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  emin_scheduler_if bus ();
  emin_scheduler dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int got_addr[$];
  int unsigned got_data[$];
  int got_iss[$];
  int exp_addr[$];
  int unsigned exp_data[$];
  int exp_iss[$];
  always @(negedge clk)
    if (rst_n) begin
      if (bus.wr_en_out) begin
        got_addr.push_back(int'(bus.wr_addr_out));
        got_data.push_back(bus.wr_data_out);
      end
      if (bus.emin_valid_out) got_iss.push_back(int'(bus.emin_i_out));
      if (bus.done_out) done_cnt++;
    end
  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(int k = 1);
    repeat (k) @(posedge clk);
    #1;
  endtask
  task automatic start(int n);
    bus.start_in = 1'b1;
    bus.n_in = NW'(n);
    step();
    bus.start_in = 1'b0;
  endtask
  task automatic clear_exp();
    exp_addr.delete();
    exp_data.delete();
    exp_iss.delete();
  endtask
  // Plays emin: for each expected i waits for the issue pulse, then returns j = 0..i with random gaps.
  task automatic serve(int n, int gmax, int bad_i, int silent_i, output int first_wait);
    int nn;
    nn = n > I ? I : n;
    first_wait = -1;
    for (int i = 0; i < nn; i++) begin
      int w;
      w = 0;
      while (!bus.emin_valid_out && w < 200) begin
        step();
        w++;
      end
      if (i == 0) first_wait = w;
      if (w == 200) begin
        checks++;
        errors++;
        $error("FAIL issue_wait i=%0d: observed no emin_valid_out expected a pulse", i);
        return;
      end
      exp_iss.push_back(i);
      if (i == silent_i) return;
      for (int j = 0; j <= i; j++) begin
        int unsigned d;
        bit bad;
        bad = (i == bad_i) && (j == 1);
        d = $urandom;
        step($urandom_range(1, gmax));
        bus.emin_valid_in = 1'b1;
        bus.emin_j_in = IW'(bad ? 2 : j);
        bus.emin_data_in = d;
        if (!bad) begin
          exp_addr.push_back(i * (i + 1) / 2 + j);
          exp_data.push_back(d);
        end
        step();
        bus.emin_valid_in = 1'b0;
        if (bad) return;
      end
    end
  endtask
  task automatic compare(string tag, int wr0, int is0);
    chk($sformatf("%s_nwr", tag), got_addr.size() - wr0, exp_addr.size());
    for (int k = 0; k < exp_addr.size() && wr0 + k < got_addr.size(); k++) begin
      chk($sformatf("%s_addr%0d", tag, k), got_addr[wr0+k], exp_addr[k]);
      chk($sformatf("%s_data%0d", tag, k), got_data[wr0+k], exp_data[k]);
    end
    chk($sformatf("%s_niss", tag), got_iss.size() - is0, exp_iss.size());
    for (int k = 0; k < exp_iss.size() && is0 + k < got_iss.size(); k++)
      chk($sformatf("%s_iss%0d", tag, k), got_iss[is0+k], exp_iss[k]);
  endtask
  task automatic expect_done(string tag, logic err);
    int d0;
    d0 = done_cnt;
    chk({tag, "_busy_pre"}, bus.busy_out, 1);
    chk({tag, "_done_pre"}, bus.done_out, 0);
    step();
    chk({tag, "_done"}, bus.done_out, 1);
    chk({tag, "_busy_fall"}, bus.busy_out, 0);
    chk({tag, "_error"}, bus.error_out, err);
    step();
    chk({tag, "_done_post"}, bus.done_out, 0);
    chk({tag, "_done_cnt"}, done_cnt - d0, 1);
  endtask
  initial begin
    int fw, wr0, is0, k;
    bus.start_in = 1'b0;
    bus.n_in = '0;
    bus.emin_valid_in = 1'b0;
    bus.emin_j_in = '0;
    bus.emin_data_in = '0;
    step(3);
    chk("rst_busy", bus.busy_out, 0);
    chk("rst_done", bus.done_out, 0);
    chk("rst_error", bus.error_out, 0);
    chk("rst_valid", bus.emin_valid_out, 0);
    chk("rst_wr_en", bus.wr_en_out, 0);
    chk("rst_wr_addr", bus.wr_addr_out, 0);
    chk("rst_i", bus.emin_i_out, 0);
    rst_n = 1'b1;
    step(2);
    clear_exp();
    wr0 = got_addr.size();
    is0 = got_iss.size();
    start(3);
    chk("n3_busy_t1", bus.busy_out, 1);
    chk("n3_valid_t1", bus.emin_valid_out, 0);
    serve(3, 3, -1, -1, fw);
    chk("n3_first_issue_t2", fw, 1);
    expect_done("n3", 1'b0);
    compare("n3", wr0, is0);
    wr0 = got_addr.size();
    bus.emin_valid_in = 1'b1;
    bus.emin_j_in = '0;
    step(2);
    bus.emin_valid_in = 1'b0;
    step(2);
    chk("idle_valid_in_nwr", got_addr.size() - wr0, 0);
    chk("idle_valid_in_err", bus.error_out, 0);
    clear_exp();
    wr0 = got_addr.size();
    is0 = got_iss.size();
    start(0);
    chk("n0_busy_t1", bus.busy_out, 1);
    chk("n0_done_t1", bus.done_out, 0);
    step();
    chk("n0_done_t2", bus.done_out, 1);
    chk("n0_busy_t2", bus.busy_out, 0);
    step(2);
    compare("n0", wr0, is0);
    clear_exp();
    wr0 = got_addr.size();
    is0 = got_iss.size();
    start(200);
    serve(200, 1, -1, -1, fw);
    expect_done("n200", 1'b0);
    compare("n200", wr0, is0);
    chk("n200_last_addr", got_addr.size() > 0 ? got_addr[$] : -1, 12879);
    chk("n200_last_i", got_iss.size() > 0 ? got_iss[$] : -1, 159);
    clear_exp();
    wr0 = got_addr.size();
    is0 = got_iss.size();
    start(3);
    serve(3, 2, 1, -1, fw);
    expect_done("badj", 1'b1);
    compare("badj", wr0, is0);
    chk("badj_err_sticky", bus.error_out, 1);
    clear_exp();
    wr0 = got_addr.size();
    is0 = got_iss.size();
    start(2);
    chk("silent_err_cleared", bus.error_out, 0);
    serve(2, 1, -1, 0, fw);
    k = 0;
    while (!bus.done_out && k < 200) begin
      step();
      k++;
    end
    chk("silent_done_delay", k, T + 2);
    chk("silent_error", bus.error_out, 1);
    step(2);
    compare("silent", wr0, is0);
    start(3);
    serve(3, 2, -1, 1, fw);
    step();
    bus.emin_valid_in = 1'b1;
    bus.emin_j_in = '0;
    bus.emin_data_in = $urandom;
    step();
    bus.emin_valid_in = 1'b0;
    chk("midrst_wr_en_pre", bus.wr_en_out, 1);
    chk("midrst_busy_pre", bus.busy_out, 1);
    k = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", bus.busy_out, 0);
    chk("midrst_wr_en", bus.wr_en_out, 0);
    chk("midrst_valid", bus.emin_valid_out, 0);
    chk("midrst_done", bus.done_out, 0);
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("midrst_no_done", done_cnt - k, 0);
    clear_exp();
    wr0 = got_addr.size();
    is0 = got_iss.size();
    start(2);
    serve(2, 3, -1, -1, fw);
    expect_done("after_rst", 1'b0);
    compare("after_rst", wr0, is0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
